// File: rtl/seg_display_mux_bcd.sv
// rtl/seg_display_mux_bcd.sv - multiplexed seven-segment driver with double-dabble BCD conversion
module seg_display_mux_bcd #(
    parameter int NUM_DIGITS  = 8,
    parameter int VALUE_W     = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [VALUE_W-1:0]            value_in,
    input  logic                          load,
    input  logic                          dp_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] dp_pos,
    input  logic                          blank_lz,
    input  logic                          blink_en,
    output logic                          busy,
    output logic                          ovf,
    output logic [7:0]                    seg_7_disp,
    output logic [NUM_DIGITS-1:0]         AN
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int REF_W = $clog2(REFRESH_DIV + 1);
    localparam int BLK_W = $clog2(BLINK_TICKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              r_state, w_state_nxt;
    logic [VALUE_W-1:0]  r_bin, r_pend_val;
    logic                r_pend;
    logic [BCD_W-1:0]    r_scratch, r_disp, w_adj;
    logic                r_sovf, r_ovf;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [REF_W-1:0]    r_ref_cnt;
    logic [BLK_W-1:0]    r_blink_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_phase;
    logic [NUM_DIGITS-1:0] r_an, w_lz;
    logic [7:0]          r_seg;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg7;
    logic                w_shift_done, w_restart, w_tick, w_blank, w_dp_on;
    logic [VALUE_W-1:0]  w_restart_val;

    assign w_shift_done  = (r_bit_cnt == CNT_W'(VALUE_W - 1));
    // A load arriving during COMMIT itself counts as pending and wins over an older one.
    assign w_restart     = r_pend | load;
    assign w_restart_val = load ? value_in : r_pend_val;
    assign busy          = (r_state != IDLE);
    assign ovf           = r_ovf;
    assign AN            = r_an;
    assign seg_7_disp    = r_seg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (load) w_state_nxt = SHIFT;
            SHIFT:   if (w_shift_done) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = w_restart ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bin      <= '0;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_scratch  <= '0;
            r_disp     <= '0;
            r_sovf     <= 1'b0;
            r_ovf      <= 1'b0;
            r_bit_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_bin     <= value_in;
                        r_scratch <= '0;
                        r_sovf    <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_scratch <= {w_adj[BCD_W-2:0], r_bin[VALUE_W-1]};
                    r_bin     <= {r_bin[VALUE_W-2:0], 1'b0};
                    r_sovf    <= r_sovf | w_adj[BCD_W-1];
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    if (load) begin
                        r_pend_val <= value_in;
                        r_pend     <= 1'b1;
                    end
                end
                COMMIT: begin
                    r_disp <= r_scratch;
                    r_ovf  <= r_sovf;
                    r_pend <= 1'b0;
                    if (w_restart) begin
                        r_bin     <= w_restart_val;
                        r_scratch <= '0;
                        r_sovf    <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_tick = (r_ref_cnt == REF_W'(REFRESH_DIV - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ref_cnt   <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            if (w_tick) begin
                r_ref_cnt <= '0;
                r_idx     <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_ref_cnt <= r_ref_cnt + REF_W'(1);
            end
            if (!blink_en) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b0;
            end else if (w_tick) begin
                if (r_blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                    r_blink_cnt <= '0;
                    r_phase     <= ~r_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BLK_W'(1);
                end
            end
        end
    end

    // w_lz[i]: digits i..NUM_DIGITS-1 of the committed value are all zero.
    always_comb begin
        logic v_acc;
        v_acc = 1'b1;
        w_lz  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_acc   = v_acc & (r_disp[4*i +: 4] == 4'd0);
            w_lz[i] = v_acc;
        end
    end

    assign w_nib   = r_disp[{r_idx, 2'b00} +: 4];
    assign w_blank = blank_lz && (r_idx != '0) && w_lz[r_idx] && !(dp_en && (r_idx <= dp_pos));
    assign w_dp_on = dp_en && (r_idx == dp_pos) && !r_ovf;

    always_comb begin
        w_seg7 = 7'h7F;
        if (r_ovf) begin
            w_seg7 = 7'b0111111;
        end else if (!w_blank) begin
            case (w_nib)
                4'd0:    w_seg7 = 7'b1000000;
                4'd1:    w_seg7 = 7'b1111001;
                4'd2:    w_seg7 = 7'b0100100;
                4'd3:    w_seg7 = 7'b0110000;
                4'd4:    w_seg7 = 7'b0011001;
                4'd5:    w_seg7 = 7'b0010010;
                4'd6:    w_seg7 = 7'b0000010;
                4'd7:    w_seg7 = 7'b1111000;
                4'd8:    w_seg7 = 7'b0000000;
                4'd9:    w_seg7 = 7'b0010000;
                default: w_seg7 = 7'h7F;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_an  <= '1;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= r_phase ? '1 : ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= {~w_dp_on, w_seg7};
        end
    end
endmodule

// File: tb/tb_seg_display_mux_bcd.sv
// tb/tb_seg_display_mux_bcd.sv - scoreboard bench for seg_display_mux_bcd
module tb_seg_display_mux_bcd;
    localparam int ND  = 4;
    localparam int VW  = 16;
    localparam int RD  = 4;
    localparam int BT  = 2;
    localparam int LAT = VW + 1;
    localparam logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                           7'b0000000, 7'b0010000};

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [VW-1:0] value_in = '0;
    logic          load = 1'b0, dp_en = 1'b0, blank_lz = 1'b0, blink_en = 1'b0;
    logic [1:0]    dp_pos = '0;
    logic          busy, ovf;
    logic [7:0]    seg_7_disp;
    logic [ND-1:0] AN;

    seg_display_mux_bcd #(.NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
        .CLK(CLK), .RST(RST), .value_in(value_in), .load(load), .dp_en(dp_en), .dp_pos(dp_pos),
        .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .ovf(ovf),
        .seg_7_disp(seg_7_disp), .AN(AN)
    );

    always #5 CLK = ~CLK;

    typedef struct { int c; int v; } conv_t;
    conv_t q[$];
    conv_t e;
    bit    exp_busy [0:8191];
    int    checks = 0, failures = 0;
    int    n = 0;
    int    last_commit = -1, pend_start = -1;
    bit    s_dp_en, s_blank_lz, s_blink;
    int    s_dp_pos;
    int    disp_val = 0, nxt_disp = 0, nxt_edge = -1;
    bit    ovf_exp = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", nm, n, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_seg(int val, int idx, bit dpe, int dpp, bit blz);
        int p = 1;
        int upper;
        bit blank;
        if (val >= 10000) return 8'b1011_1111;
        for (int k = 0; k < idx; k++) p = p * 10;
        upper = val / p;
        blank = blz && idx > 0 && upper == 0 && !(dpe && idx <= dpp);
        return {~(dpe && idx == dpp), blank ? 7'h7F : SEG_TBL[upper % 10]};
    endfunction

    // Conversion timing model: a free converter starts at the load edge; a load while busy
    // queues behind the in-flight one, and later loads before it starts replace its value.
    task automatic model_load(input int ed, input int v);
        int c;
        conv_t t;
        if (ed > last_commit) begin
            c = ed + LAT;
            q.push_back('{c, v});
            pend_start = -1;
        end else if (pend_start >= 0 && ed <= pend_start) begin
            t = q[q.size()-1];
            t.v = v;
            q[q.size()-1] = t;
            return;
        end else begin
            c = last_commit + LAT;
            pend_start = last_commit;
            q.push_back('{c, v});
        end
        last_commit = c;
        for (int k = c - LAT; k < c; k++) if (k >= 0 && k < 8192) exp_busy[k] = 1'b1;
    endtask

    always @(posedge CLK) begin
        n          = RST ? 0 : n + 1;
        s_dp_en    = dp_en;
        s_dp_pos   = int'(dp_pos);
        s_blank_lz = blank_lz;
        s_blink    = blink_en;
    end

    always @(negedge CLK) begin
        int slot, idx;
        bit ph;
        logic [ND-1:0] ea;
        if (RST) begin
            chk("rst_busy", busy, 0);
            chk("rst_ovf", ovf, 0);
            chk("rst_an", AN, 4'hF);
            chk("rst_seg", seg_7_disp, 8'hFF);
            disp_val = 0;
            ovf_exp  = 0;
            nxt_edge = -1;
        end else if (n >= 1) begin
            if (n == nxt_edge) disp_val = nxt_disp;
            if (q.size() > 0 && q[0].c == n) begin
                e = q.pop_front();
                ovf_exp  = (e.v >= 10000);
                nxt_disp = e.v;
                nxt_edge = n + 1;
                chk("commit_ovf", ovf, ovf_exp);
            end
            chk("busy", busy, (n < 8192) ? exp_busy[n] : 0);
            chk("ovf", ovf, ovf_exp);
            slot = (n - 1) / RD;
            idx  = slot % ND;
            ph   = s_blink && ((slot / BT) % 2 == 1);
            ea   = ph ? 4'hF : ~(4'b0001 << idx);
            chk("an", AN, ea);
            if (!ph) chk("seg", seg_7_disp, ref_seg(disp_val, idx, s_dp_en, s_dp_pos, s_blank_lz));
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge CLK);
    endtask

    task automatic do_load(input int v);
        @(negedge CLK);
        value_in = VW'(v);
        load     = 1'b1;
        model_load(n + 1, v);
        @(negedge CLK);
        load = 1'b0;
    endtask

    task automatic do_reset(input bit blink);
        @(negedge CLK);
        #2 RST = 1'b1;
        q.delete();
        for (int k = 0; k < 8192; k++) exp_busy[k] = 1'b0;
        last_commit = -1;
        pend_start  = -1;
        blink_en    = blink;
        #1;
        chk("async_busy", busy, 0);
        chk("async_an", AN, 4'hF);
        chk("async_seg", seg_7_disp, 8'hFF);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
    endtask

    initial begin
        int r, v;
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        tick(20);
        blank_lz = 1'b1;
        tick(20);
        do_load(25);
        tick(40);
        dp_en = 1'b1; dp_pos = 2'd2;
        do_load(50);
        tick(40);
        dp_en = 1'b0;
        do_load(12345);
        tick(40);
        do_load(9999);
        tick(40);
        do_load(25);
        tick(2);
        do_load(50);
        tick(60);
        do_load(111);
        tick(1);
        do_load(222);
        tick(1);
        do_load(333);
        tick(60);
        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 3);
            v = (r == 0) ? $urandom_range(0, 99) : (r == 1) ? $urandom_range(0, 65535) : $urandom_range(0, 9999);
            dp_en    = $urandom_range(0, 1);
            dp_pos   = 2'($urandom_range(0, 3));
            blank_lz = $urandom_range(0, 1);
            do_load(v);
            tick($urandom_range(1, 30));
            if ($urandom_range(0, 1) == 1) begin
                dp_en    = $urandom_range(0, 1);
                dp_pos   = 2'($urandom_range(0, 3));
                blank_lz = $urandom_range(0, 1);
                tick(20);
            end
        end
        tick(40);
        dp_en = 1'b0; blank_lz = 1'b1;
        do_load(1234);
        tick(7);
        do_reset(1'b1);
        tick(70);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg_display_mux_bcd.md
Name: seg_display_mux_bcd

Overview:
Parametrised time-multiplexed seven-segment driver for the vending-machine display. It accepts an arbitrary binary value and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It scans NUM_DIGITS common-anode digits and supports a programmable decimal point, leading-zero blanking, overflow indication and display blink. It sits between the vending FSM (amount inserted / change / price) and the board display pins.

Parameters:
NUM_DIGITS, 8, number of physical digits scanned (2..8)
VALUE_W, 16, width of binary input value
REFRESH_DIV, 100000, CLK cycles per digit slot (1 ms at 100 MHz)
BLINK_TICKS, 250, digit-slot ticks per blink half-period

Ports:
CLK  input  1  system clock
RST  input  1  reset
value_in  input  VALUE_W  unsigned binary value to display
load  input  1  single-cycle request to convert and show value_in
dp_en  input  1  enable decimal point
dp_pos  input  $clog2(NUM_DIGITS)  digit index carrying DP (0 = rightmost)
blank_lz  input  1  blank leading zeros
blink_en  input  1  blink whole display
busy  output  1  conversion in progress
ovf  output  1  last committed value exceeded NUM_DIGITS decimal digits
seg_7_disp  output  8  segments, active low; bit7=DP, bit6=CG ... bit0=CA
AN  output  NUM_DIGITS  digit enables, active low, one-hot-low

Behaviour:
- Reset: RST asynchronous, active-high; clock CLK. All state is cleared as follows: busy=0, ovf=0, AN=all ones, seg_7_disp=8'hFF, display BCD register=0, digit index=0, refresh/blink counters=0, blink phase=0, pending flag=0.
- Outputs AN and seg_7_disp are registered. They first take scan values on the first CLK edge after reset release.
- Converter FSM states IDLE, SHIFT, COMMIT:
  - IDLE: when load=1, capture value_in, clear the BCD scratch register and go to SHIFT. busy=1 from the next cycle.
  - SHIFT: exactly VALUE_W cycles. Each cycle, add 3 to every scratch BCD nibble >=5, then shift left 1 with the binary MSB entering. A 1 shifted out of the top nibble sets a sticky overflow scratch bit.
  - COMMIT: 1 cycle. Copy scratch to the display register and copy overflow to ovf. Go to IDLE, or directly restart SHIFT if pending. busy falls on the edge leaving COMMIT, unless restarting.
- Latency: load sampled at edge 0 → display register and ovf updated at edge VALUE_W+1. busy is high for VALUE_W+1 cycles.
- load while busy: latch value_in into the pending register (last one wins) and set pending. The in-flight conversion still commits; the pending conversion starts in the cycle after COMMIT.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1. On the terminal count, the digit index increments and wraps NUM_DIGITS-1 → 0.
  - AN drives the indexed bit low and all other bits high.
- Segment encoding (active low, DP bit excluded):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - dash=0111111; blank=1111111.
- DP bit = 0 (lit) iff dp_en=1 and index==dp_pos and ovf=0.
- Leading-zero blanking: digit i is blank iff all of the following hold:
  - blank_lz=1;
  - digits i..NUM_DIGITS-1 are all zero;
  - i>0;
  - not (dp_en=1 and i<=dp_pos).
  - Digit 0 and every digit at or right of the DP always show.
- ovf=1: every digit shows a dash with DP off, irrespective of blank_lz.
- Blink: when blink_en=1, the phase toggles every BLINK_TICKS refresh ticks, and AN is forced all ones while phase=1. When blink_en=0, the phase and blink counter are held at 0.
- Input changes on dp_en, dp_pos, blank_lz affect output on the next registered update. No reconversion is needed.
- dp_pos >= NUM_DIGITS: no DP is lit.

Test Plan:
(All scenarios use NUM_DIGITS=4, VALUE_W=16, REFRESH_DIV=4, BLINK_TICKS=2.)
- Scan: reset, no load → AN cycles 1110,1101,1011,0111,1110, each held 4 CLK. Segs: digit0 8'b1100_0000; with blank_lz=1, digits1-3 8'hFF.
- Conversion: load value_in=25, blank_lz=1 → busy high 17 cycles. Then digit0=8'b1001_0010, digit1=8'b1010_0100, digits2-3=8'hFF, ovf=0.
- Decimal point: value 50, dp_en=1, dp_pos=2, blank_lz=1 → digit2=8'b0100_0000 ("0."), digit1=8'b1001_0010, digit0=8'b1100_0000, digit3=8'hFF.
- Overflow: load 12345 → ovf=1, all four digits 8'b1011_1111. Then load 9999 → ovf=0, digits show 9,9,9,9 (8'b1001_0000).
- Pending load: load 25 at cycle 0, load 50 at cycle 3 → 25 committed at edge 17, 50 committed at edge 34, busy continuous from cycle 1 to 34.
- Reset mid-operation: assert RST at SHIFT cycle 8 → busy=0, AN=1111, seg=8'hFF, display register=0. Blink_en=1 after release → AN all ones for 8-cycle windows alternating with normal scan.
